// File: rtl/dr_tx_4phase_pkg.sv
// Shared definitions for the dual-rail 4-phase transmitter:
// FSM state encoding, rail codes and the per-bit rail encoder.
package dr_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_NULL = 2'd2
    } state_t;

    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_T    = 2'b10;
    localparam logic [1:0] DR_F    = 2'b01;

    // One data bit to its dual-rail pair (never the illegal 11).
    function automatic logic [1:0] dr_rail(input logic b);
        return b ? DR_T : DR_F;
    endfunction

endpackage

// File: rtl/dr_tx_4phase_if.sv
// Bundle of the producer-side handshake and dual-rail bus signals.
// Ports: none; master = side that offers words and returns acks,
// slave = the transmitter that accepts words and drives the rails.
interface dr_tx_4phase_if #(
    parameter int WIDTH = 8,
    parameter int N_ACK = 4
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [2*WIDTH-1:0]   data_out;
    logic [N_ACK-1:0]     ack;
    logic                 busy;
    logic                 err;

    modport master (
        output in_valid,
        output in_data,
        output ack,
        input  in_ready,
        input  data_out,
        input  busy,
        input  err
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  ack,
        output in_ready,
        output data_out,
        output busy,
        output err
    );

endinterface

// File: rtl/dr_tx_4phase_ack_sync.sv
// Per-bit multi-flop synchronizer for the asynchronous acknowledges.
// Ports: clk, rst (sync, active-high), async_in[WIDTH] raw acks,
// sync_out = last stage, sync_next = stage feeding it, filled = all
// stages have been loaded with real samples since reset.
module ack_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] sync_next,
    output logic             filled
);

    logic [STAGES-1:0][WIDTH-1:0] q;
    logic [STAGES-1:0]            fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            fill <= '0;
        end else begin
            q    <= {q[STAGES-2:0], async_in};
            fill <= {fill[STAGES-2:0], 1'b1};
        end
    end

    assign sync_out  = q[STAGES-1];
    assign sync_next = q[STAGES-2];
    assign filled    = fill[STAGES-1];

endmodule

// File: rtl/dr_tx_4phase.sv
// Parallel word to dual-rail 4-phase (RZ) transmitter with forked acks.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data word
// handshake; data_out dual-rail rails (pair i at [2i+1:2i], 00 spacer);
// ack[N_ACK] async consumer acks; busy = FSM not idle; err = watchdog.
// Optional watchdog built only when DR_TX_TIMEOUT_EN is defined.
module dr_tx_4phase
    import dr_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int N_ACK       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic [2*WIDTH-1:0] data_out,
    input  logic [N_ACK-1:0]   ack,
    output logic               busy,
    output logic               err
);

    if (SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("dr_tx_4phase: SYNC_STAGES >= 2 and TIMEOUT_CYC >= 1");
    end

    state_t             state, state_d;
    logic [2*WIDTH-1:0] data_d;
    logic [2*WIDTH-1:0] code;
    logic               busy_d;
    logic [N_ACK-1:0]   ack_s;
    logic [N_ACK-1:0]   ack_n;
    logic               sync_ok;
    logic               accept;
    logic               acks_hi;
    logic               acks_lo;

    ack_sync #(
        .WIDTH  (N_ACK),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .async_in  (ack),
        .sync_out  (ack_s),
        .sync_next (ack_n),
        .filled    (sync_ok)
    );

    // The FSM moves on the same edge at which ack_s takes its new value,
    // so it decides on the stage feeding ack_s. This keeps the spacer and
    // in_ready aligned with ack_s and saves one cycle per phase.
    assign acks_hi = &ack_n;
    assign acks_lo = ~|ack_n;

    // sync_ok masks the zeros left in the synchronizer by reset, so a
    // consumer still holding its ack high cannot be mistaken for idle.
    assign in_ready = (state == S_IDLE) && sync_ok && ~|ack_s;
    assign accept   = in_valid && in_ready;

    always_comb begin
        code = '0;
        for (int i = 0; i < WIDTH; i++) begin
            code[2*i +: 2] = dr_rail(in_data[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            data_out <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            data_out <= data_d;
            busy     <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:  if (accept)  state_d = S_DATA;
            S_DATA:  if (acks_hi) state_d = S_NULL;
            S_NULL:  if (acks_lo) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d = data_out;
        busy_d = (state_d != S_IDLE);
        if (state == S_IDLE && accept) begin
            data_d = code;
        end else if (state == S_DATA && acks_hi) begin
            data_d = '0;
        end
    end

`ifdef DR_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 2);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

    logic [CW-1:0] cnt, cnt_d;
    logic          err_d;

    // err looks at the next count so it rises on the edge the count
    // reaches the limit; the FSM itself is never forced out of a phase.
    always_comb begin
        cnt_d = cnt;
        if (state_d != state) begin
            cnt_d = '0;
        end else if (state != S_IDLE && cnt != '1) begin
            cnt_d = cnt + 1'b1;
        end
        err_d = err || (cnt_d >= LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_d;
            err <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
